ber_prbs_check: RTL and testbench
=================================

Name: ber_prbs_check

Overview:
- Receive-side PRBS7 checker that produces the measurement counts consumed by the BER 7-segment display block.
- Locks a local LFSR to an incoming serial PRBS7 stream (x^7+x^6+1), then counts received and errored bits while locked.
- Presents periodic count snapshots with a one-cycle START strobe, matching the display block's RECV_CNT/ERR_CNT/START interface.

Parameters:
- LOCK_THRESH, 64, consecutive matching bits in VERIFY required to enter LOCKED (range 1..255).
- WIN_LEN, 256, bit window in LOCKED over which errors are tallied for loss-of-lock (power of 2, max 65536).
- UNLOCK_ERR, 16, errors within one window that force loss of lock (range 1..WIN_LEN).
- REPORT_CYC, 50000000, CLK cycles between snapshots (range 2..2^32-1).

Ports:
- CLK  input  1  clock
- RSTX  input  1  asynchronous active-low reset
- DIN  input  1  received serial bit
- DIN_VALID  input  1  DIN is a new bit this cycle
- CLEAR  input  1  synchronous: zero live counters and report timer
- LOCK  output  1  checker in LOCKED state
- START  output  1  one-cycle strobe; snapshot outputs updated this cycle
- RECV_CNT  output  58  snapshot of locked bits received since CLEAR/reset
- ERR_CNT  output  64  snapshot of errored bits since CLEAR/reset

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RSTX). All registers clear. LOCK=0, START=0, RECV_CNT=0, ERR_CNT=0, state=SEED, LFSR=0, all counters=0.
- LFSR: 7-bit shift register, lfsr[0] = newest bit. Predicted bit p = lfsr[6]^lfsr[5]. Advances only on cycles with DIN_VALID=1.
- SEED: each valid bit shifts DIN into the LFSR; seed counter increments. After 7 valid bits, go to VERIFY with match counter=0. If the shifted-in state is all-zero, stay in SEED and restart the seed count.
- VERIFY: on a valid bit, shift DIN in and compare DIN against p.
  - Mismatch: go to SEED (seed count=0).
  - Match: match counter+1. When it reaches LOCK_THRESH, go to LOCKED with LOCK=1 registered in the same cycle.
  - No counting in VERIFY.
- LOCKED: on a valid bit, shift p in (flywheel, not DIN).
  - rx_live += 1.
  - If DIN != p: err_live += 1 and win_err += 1.
  - win_pos increments per valid bit. At wrap (WIN_LEN-th bit), win_err reloads with this bit's error (0/1).
  - If win_err+this error reaches UNLOCK_ERR: go to SEED and LOCK=0 next cycle. This bit is still counted.
- Live counters: rx_live is 58b and err_live is 64b. Both saturate at all-ones. Once rx_live saturates, neither increments.
- Report timer: 32b, counts every cycle from 0 to REPORT_CYC-1 and wraps. On the wrap cycle, the snapshots load the live counters' next-state values (including this cycle's bit) and START=1 is registered. START, RECV_CNT and ERR_CNT change on the same edge. START is high exactly one cycle; the snapshots hold until the next strobe.
- CLEAR (synchronous, priority over increments):
  - rx_live=0, err_live=0, timer=0.
  - A strobe due in that cycle is suppressed.
  - Snapshots, LOCK, state and LFSR are unaffected.
- DIN_VALID=0: no state, LFSR, window or count changes. The timer still runs.
- Invariant: RECV_CNT changes only together with START.
- RSTX assertion mid-operation: immediate return to reset values.

Test Plan:
- Clean PRBS7, DIN_VALID=1 every cycle, REPORT_CYC=1000 → LOCK=1 at bit 7+64=71 (registered). First START at cycle 1000 with RECV_CNT=929, ERR_CNT=0. Following strobes show +1000 each.
- Locked, inject 3 isolated bit flips within 100 bits → ERR_CNT increments by exactly 3. LOCK stays 1. The flywheel LFSR does not lose alignment (no further errors).
- Locked, invert 16 bits inside one 256-bit window → LOCK falls after the 16th error, with ERR_CNT including all 16. Relock occurs after 71 clean bits. RECV_CNT is frozen while unlocked.
- Error during VERIFY at match 40 → return to SEED, no counts. LOCK only after a fresh 7+64 clean bits.
- CLEAR pulsed one cycle before a strobe → no START that period. Next START after REPORT_CYC cycles, counting only bits after CLEAR. LOCK is unaffected.
- DIN_VALID toggling 1/0 on clean data → RECV_CNT per period = half the locked cycles. Assert RSTX mid-run → all outputs 0 asynchronously, and relock after 71 valid bits.

Source files
------------

// File: rtl/ber_prbs_check.sv
// Receive-side PRBS7 (x^7+x^6+1) checker: locks to the incoming stream,
// counts locked and errored bits, and publishes periodic snapshots.
module ber_prbs_check #(
    parameter int unsigned LOCK_THRESH = 64,
    parameter int unsigned WIN_LEN     = 256,
    parameter int unsigned UNLOCK_ERR  = 16,
    parameter int unsigned REPORT_CYC  = 50000000
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        DIN,
    input  logic        DIN_VALID,
    input  logic        CLEAR,
    output logic        LOCK,
    output logic        START,
    output logic [57:0] RECV_CNT,
    output logic [63:0] ERR_CNT
);

    localparam int WPW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    state_t         state;
    logic [6:0]     lfsr;
    logic [2:0]     seed_cnt;
    logic [7:0]     match_cnt;
    logic [WPW-1:0] win_pos;
    logic [16:0]    win_err;
    logic [57:0]    rx_live;
    logic [63:0]    err_live;
    logic [31:0]    timer;

    logic        pred;
    logic        bit_err;
    logic [6:0]  lfsr_din;
    logic [16:0] win_sum;
    logic        wrap;
    logic        cnt_en;
    logic        tick;
    logic [57:0] rx_nxt;
    logic [63:0] err_nxt;

    always_comb begin
        pred     = lfsr[6] ^ lfsr[5];
        bit_err  = DIN ^ pred;
        lfsr_din = {lfsr[5:0], DIN};
        win_sum  = win_err + 17'(bit_err);
        wrap     = (win_pos == WPW'(WIN_LEN - 1));
        // a saturated receive count freezes both counters
        cnt_en   = DIN_VALID && (state == LOCKED) && !(&rx_live);
        rx_nxt   = rx_live + 58'(cnt_en);
        err_nxt  = err_live + 64'(cnt_en & bit_err & ~(&err_live));
        tick     = (timer == 32'(REPORT_CYC - 1));
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state     <= SEED;
            lfsr      <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            LOCK      <= 1'b0;
        end else if (DIN_VALID) begin
            unique case (state)
                SEED: begin
                    lfsr <= lfsr_din;
                    if (seed_cnt == 3'd6) begin
                        seed_cnt <= '0;
                        if (lfsr_din != 7'd0) begin
                            state     <= VERIFY;
                            match_cnt <= '0;
                        end
                    end else begin
                        seed_cnt <= seed_cnt + 3'd1;
                    end
                end
                VERIFY: begin
                    lfsr <= lfsr_din;
                    if (bit_err) begin
                        state    <= SEED;
                        seed_cnt <= '0;
                    end else if (match_cnt == 8'(LOCK_THRESH - 1)) begin
                        state   <= LOCKED;
                        LOCK    <= 1'b1;
                        win_pos <= '0;
                        win_err <= '0;
                    end else begin
                        match_cnt <= match_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    // flywheel: keep our own sequence, ignore DIN
                    lfsr    <= {lfsr[5:0], pred};
                    win_pos <= wrap ? '0 : win_pos + WPW'(1);
                    win_err <= wrap ? 17'(bit_err) : win_sum;
                    if (win_sum >= 17'(UNLOCK_ERR)) begin
                        state    <= SEED;
                        seed_cnt <= '0;
                        LOCK     <= 1'b0;
                    end
                end
                default: begin
                    state <= SEED;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            rx_live  <= '0;
            err_live <= '0;
            timer    <= '0;
            START    <= 1'b0;
            RECV_CNT <= '0;
            ERR_CNT  <= '0;
        end else begin
            START <= 1'b0;
            if (CLEAR) begin
                rx_live  <= '0;
                err_live <= '0;
                timer    <= '0;
            end else begin
                rx_live  <= rx_nxt;
                err_live <= err_nxt;
                if (tick) begin
                    timer    <= '0;
                    START    <= 1'b1;
                    RECV_CNT <= rx_nxt;
                    ERR_CNT  <= err_nxt;
                end else begin
                    timer <= timer + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ber_prbs_check.sv
// Randomised bench for ber_prbs_check: a bit-history reference model feeds
// a per-cycle expectation queue that an independent monitor drains.
module tb_ber_prbs_check;

    localparam int LOCK_THRESH = 64;
    localparam int WIN_LEN     = 256;
    localparam int UNLOCK_ERR  = 16;
    localparam int REPORT_CYC  = 1000;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic        DIN = 1'b0;
    logic        DIN_VALID = 1'b0;
    logic        CLEAR = 1'b0;
    logic        LOCK;
    logic        START;
    logic [57:0] RECV_CNT;
    logic [63:0] ERR_CNT;

    ber_prbs_check #(
        .LOCK_THRESH(LOCK_THRESH),
        .WIN_LEN    (WIN_LEN),
        .UNLOCK_ERR (UNLOCK_ERR),
        .REPORT_CYC (REPORT_CYC)
    ) dut (
        .CLK      (CLK),
        .RSTX     (RSTX),
        .DIN      (DIN),
        .DIN_VALID(DIN_VALID),
        .CLEAR    (CLEAR),
        .LOCK     (LOCK),
        .START    (START),
        .RECV_CNT (RECV_CNT),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        lock;
        logic        start;
        logic [57:0] recv;
        logic [63:0] err;
        int          cyc;
        int          epoch;
    } obs_t;

    obs_t exp_q[$];

    // reference model state: phase 0=seed 1=verify 2=locked
    int          mph;
    logic        seq[$];
    int          mseed, mmatch, mwpos, mwerr, mt, mcyc, mepoch;
    int          exp_starts = 0;
    logic [57:0] mrx, msrx;
    logic [63:0] merr, mserr;

    logic [6:0] g;
    int         flip_q[$];
    int         clear_at = -1;

    int     n_chk = 0;
    int     n_pass = 0;
    int     n_start = 0;
    longint first_recv = -1;
    int     lock0 = -1;
    int     lock1 = -1;
    bit     fin = 0;
    bit     mon_done = 0;
    obs_t   me;

    function automatic void model_reset();
        mph = 0;
        seq.delete();
        for (int k = 0; k < 7; k++) seq.push_back(1'b0);
        mseed = 0; mmatch = 0; mwpos = 0; mwerr = 0;
        mt = 0; mcyc = 0;
        mrx = '0; msrx = '0; merr = '0; mserr = '0;
    endfunction

    function automatic void push_zero();
        obs_t o;
        o.lock = 1'b0; o.start = 1'b0; o.recv = '0; o.err = '0;
        o.cyc = 0; o.epoch = mepoch;
        exp_q.push_back(o);
    endfunction

    function automatic void model_cycle(input logic d, input logic v,
                                        input logic c);
        logic st, pred, e, any;
        obs_t o;
        st = 1'b0;
        mcyc++;
        if (v) begin
            pred = seq[0] ^ seq[1];
            if (mph == 0) begin
                seq.push_back(d);
                void'(seq.pop_front());
                mseed++;
                if (mseed == 7) begin
                    mseed = 0;
                    any = 1'b0;
                    foreach (seq[k]) any = any | seq[k];
                    if (any) begin mph = 1; mmatch = 0; end
                end
            end else if (mph == 1) begin
                seq.push_back(d);
                void'(seq.pop_front());
                if (d != pred) begin
                    mph = 0; mseed = 0;
                end else begin
                    mmatch++;
                    if (mmatch == LOCK_THRESH) begin
                        mph = 2; mwpos = 0; mwerr = 0;
                    end
                end
            end else begin
                seq.push_back(pred);
                void'(seq.pop_front());
                e = d ^ pred;
                if (mrx != '1) begin
                    mrx++;
                    if (e && merr != '1) merr++;
                end
                if (mwerr + int'(e) >= UNLOCK_ERR) begin
                    mph = 0; mseed = 0;
                end
                mwpos++;
                if (mwpos == WIN_LEN) begin
                    mwpos = 0; mwerr = int'(e);
                end else begin
                    mwerr += int'(e);
                end
            end
        end
        if (c) begin
            mrx = '0; merr = '0; mt = 0;
        end else if (mt == REPORT_CYC - 1) begin
            mt = 0; msrx = mrx; mserr = merr; st = 1'b1;
            exp_starts++;
        end else begin
            mt++;
        end
        o.lock = (mph == 2); o.start = st;
        o.recv = msrx; o.err = mserr;
        o.cyc = mcyc; o.epoch = mepoch;
        exp_q.push_back(o);
    endfunction

    function automatic logic gen_bit();
        logic nb;
        nb = g[6] ^ g[5];
        g = {g[5:0], nb};
        return nb;
    endfunction

    function automatic bit is_flip(input int k);
        foreach (flip_q[j]) if (flip_q[j] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic d, input logic v, input logic c);
        @(negedge CLK);
        DIN = d; DIN_VALID = v; CLEAR = c;
        model_cycle(d, v, c);
    endtask

    // vmode: 0 every cycle, 1 alternate, 2 random; prand: flips per 1000
    task automatic run(input int n, input int vmode, input int prand);
        int vi;
        logic v, d, c;
        vi = 0;
        for (int i = 0; i < n; i++) begin
            v = 1'b1;
            if (vmode == 1) v = (i % 2 == 0);
            else if (vmode == 2) v = 1'($urandom_range(0, 1));
            d = 1'($urandom);
            if (v) begin
                d = gen_bit();
                if (is_flip(vi) ||
                    (prand > 0 && $urandom_range(0, 999) < prand))
                    d = ~d;
                vi++;
            end
            c = (clear_at >= 0 && mt == clear_at);
            if (c) clear_at = -1;
            step(d, v, c);
        end
        flip_q.delete();
    endtask

    always begin
        @(posedge CLK or negedge RSTX);
        #1;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            n_chk++;
            if (LOCK === me.lock && START === me.start &&
                RECV_CNT === me.recv && ERR_CNT === me.err) begin
                n_pass++;
            end else begin
                $display("FAIL obs cyc=%0d ep=%0d got lock=%0b start=%0b recv=%0d err=%0d want lock=%0b start=%0b recv=%0d err=%0d",
                         me.cyc, me.epoch, LOCK, START, RECV_CNT, ERR_CNT,
                         me.lock, me.start, me.recv, me.err);
            end
            if (START === 1'b1) begin
                n_start++;
                if (first_recv < 0) first_recv = longint'(RECV_CNT);
            end
            if (LOCK === 1'b1) begin
                if (me.epoch == 0 && lock0 < 0) lock0 = me.cyc;
                if (me.epoch == 1 && lock1 < 0) lock1 = me.cyc;
            end
        end else if (fin && !mon_done) begin
            n_chk++;
            if (n_start == exp_starts) n_pass++;
            else $display("FAIL start_count got %0d want %0d",
                          n_start, exp_starts);
            n_chk++;
            if (first_recv == 929) n_pass++;
            else $display("FAIL first_recv got %0d want 929", first_recv);
            n_chk++;
            if (lock0 == 71) n_pass++;
            else $display("FAIL lock_bit got %0d want 71", lock0);
            n_chk++;
            if (lock1 == 71) n_pass++;
            else $display("FAIL relock_bit got %0d want 71", lock1);
            mon_done = 1'b1;
        end
    end

    initial begin
        int f0;
        mepoch = 0;
        model_reset();
        g = 7'($urandom_range(1, 127));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            push_zero();
        end
        @(posedge CLK);
        #3 RSTX = 1'b1;

        run(3000, 0, 0);

        flip_q = '{50, 80, 110};
        run(300, 0, 0);

        f0 = (WIN_LEN - mwpos) % WIN_LEN + 10;
        for (int k = 0; k < 16; k++) flip_q.push_back(f0 + k);
        flip_q.push_back(f0 + 15 + 48);
        run(600, 0, 0);

        clear_at = REPORT_CYC - 2;
        run(2500, 0, 0);
        clear_at = REPORT_CYC - 1;
        run(2500, 0, 0);

        run(3000, 1, 0);
        run(3000, 2, 3);

        @(posedge CLK);
        #3;
        mepoch = 1;
        model_reset();
        push_zero();
        RSTX = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            push_zero();
        end
        @(posedge CLK);
        #3 RSTX = 1'b1;
        run(1500, 0, 0);

        fin = 1'b1;
        for (int i = 0; i < 100 && !mon_done; i++) @(posedge CLK);
        #2;
        if (!mon_done) begin
            $display("FAIL monitor_timeout queue=%0d", exp_q.size());
            $fatal(1, "monitor did not drain");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
